game_ctrl_fsm: RTL and testbench
================================

// Module: game_ctrl_fsm
// PURPOSE
//  Parametrised, single-clock Tetris game controller: spawn, gravity, button moves, lock, row clear, game over.
//  Proposes every candidate piece position to the external collision checker (req/ack). Commits only positions the checker passes.
//  Drives the lock-into-board and row-clear engines, and tracks lines and level. Gravity speeds up as the level rises.
// PARAMETERS
//  BOARD_W     10      board columns; legal x = 0..BOARD_W-1
//  BOARD_H     16      board rows; legal y = 0..BOARD_H-1; spawn row = BOARD_H-1
//  X_W         4       width of x coordinate (>= clog2(BOARD_W))
//  Y_W         4       width of y coordinate (>= clog2(BOARD_H))
//  GRAV_W      20      gravity counter width
//  GRAV_BASE   800000  gravity period in clocks at level 0
//  LVL_W       4       level width; MAX_LEVEL = 2**LVL_W-1
//  LINES_PER_LVL 10    cleared lines needed per level step
//  LINE_W      12      lines-cleared counter width
// PORTS
//  clka          in   1       system clock, rising edge
//  restart_n     in   1       async active-low reset
//  start         in   1       1-cycle pulse: start a game (IDLE or OVER)
//  btn_left      in   1       1-cycle pulse, already debounced
//  btn_right     in   1       1-cycle pulse
//  btn_rotate    in   1       1-cycle pulse
//  btn_down      in   1       1-cycle pulse (soft drop)
//  rand_piece    in   3       piece id from the randomizer, values 0..6
//  test_req      out  1       candidate valid; held until test_ack
//  test_piece    out  3       candidate piece
//  test_x        out  X_W     candidate x
//  test_y        out  Y_W     candidate y
//  test_rot      out  2       candidate rotation
//  test_ack      in   1       checker done; test_ok is sampled in the same cycle
//  test_ok       in   1       1 = candidate fits
//  lock_req      out  1       write cur_* into the board; held until lock_ack
//  lock_ack      in   1       board write done
//  clear_req     out  1       scan and clear full rows; held until clear_ack
//  clear_ack     in   1       clear done
//  clear_rows    in   3       rows cleared (0..4); valid with clear_ack
//  cur_piece     out  3       committed piece
//  cur_x         out  X_W     committed x
//  cur_y         out  Y_W     committed y
//  cur_rot       out  2       committed rotation
//  lines         out  LINE_W  total lines cleared; saturates at all-ones
//  level         out  LVL_W   current level; saturates at MAX_LEVEL
//  game_over     out  1       high in OVER
//  state         out  4       state code, for debug
// BEHAVIOUR
//  Reset (async, restart_n=0): all outputs 0, state=IDLE, gravity counter=0, pending move cleared.
//  State codes: IDLE=0, SPAWN=1, PLAY=2, TEST=3, LOCK=4, CLEAR=5, OVER=6. Unused codes go to IDLE.
//  IDLE: on start, clear lines, level and gravity counter, then go to SPAWN.
//  SPAWN: latch rand_piece. Candidate = (x=BOARD_W/2-2, y=BOARD_H-1, rot=0). Go to TEST with kind=SPAWN.
//  PLAY: gravity counter increments every cycle. At period = max(GRAV_BASE>>level, 1) it reloads to 0 and sets grav_pend.
//   Button pulses arriving in any state are captured into one pending-move register.
//   The latest pulse wins; within a cycle the priority is left > right > rotate > down.
//   Each cycle in PLAY, if a pending move or grav_pend exists, issue exactly one candidate and go to TEST.
//   Button moves go before gravity; grav_pend stays set until it is served.
//  Candidates: left x-1, right x+1, rotate (rot+1) mod 4 (3->0 wraps), down/gravity y-1.
//   Out-of-range candidates (left at x=0, right at x=BOARD_W-1, down at y=0) fail internally.
//   For these, test_req is not raised, and the next cycle behaves as test_ok=0.
//  TEST: test_req=1 with candidate outputs held stable until test_ack. Latency is 1 cycle minimum, unbounded maximum.
//   ok=1: commit the candidate to cur_*, clear the served pending flag, go to PLAY.
//   ok=0, kind=SPAWN: go to OVER.
//   ok=0, kind=down/gravity: go to LOCK.
//   ok=0, kind=left/right/rotate: drop the move, go to PLAY.
//  LOCK: lock_req=1 until lock_ack, then go to CLEAR.
//  CLEAR: clear_req=1 until clear_ack. Then add clear_rows to lines (saturating) and go to SPAWN.
//   Level step: a rows-since-level counter accumulates clear_rows. When it reaches >= LINES_PER_LVL,
//   subtract LINES_PER_LVL and increment level (saturating). At most one level step per clear.
//  OVER: game_over=1 and cur_* are held. On start, return to IDLE behaviour, taking the same cycle path as IDLE.
//  start is ignored outside IDLE and OVER. A handshake is never abandoned except by reset.
//  Reset asserted mid-handshake drops every req immediately.
// TESTING
//  T1 reset, start, rand_piece=3, ack ok=1 -> test_x=3 test_y=15 rot=0; cur_*=(3,15,0); state=PLAY.
//  T2 PLAY at x=0, btn_left -> no test_req, cur_x stays 0. Then btn_rotate with cur_rot=3 -> test_rot=0.
//  T3 GRAV_BASE=8: gravity candidates every 8 clks. Ack ok=0 at y=5 -> lock_req, then clear_req.
//     clear_rows=4 -> lines=4. Then SPAWN.
//  T4 btn_right and gravity tick in the same cycle -> right is tested first, gravity tested next; both served.
//  T5 three clears with clear_rows=4 (LINES_PER_LVL=10) -> level 0,0,1; lines=12; gravity period halves.
//  T6 spawn test ok=0 -> game_over=1, state=OVER. Then start -> lines=0, level=0, new spawn.
//     Also: restart_n low during TEST -> test_req=0 asynchronously.

Source files
------------

// File: rtl/game_ctrl_if.sv
// game_ctrl_if: handshakes between the game controller and its collision, lock and row-clear engines.
interface game_ctrl_if #(
  parameter int X_W = 4,
  parameter int Y_W = 4
);
  logic           test_req;
  logic [2:0]     test_piece;
  logic [X_W-1:0] test_x;
  logic [Y_W-1:0] test_y;
  logic [1:0]     test_rot;
  logic           test_ack;
  logic           test_ok;
  logic           lock_req;
  logic           lock_ack;
  logic           clear_req;
  logic           clear_ack;
  logic [2:0]     clear_rows;
  modport master (
    output test_req, test_piece, test_x, test_y, test_rot, lock_req, clear_req,
    input  test_ack, test_ok, lock_ack, clear_ack, clear_rows
  );
  modport slave (
    input  test_req, test_piece, test_x, test_y, test_rot, lock_req, clear_req,
    output test_ack, test_ok, lock_ack, clear_ack, clear_rows
  );
endinterface

// File: rtl/game_ctrl_fsm.sv
// game_ctrl_fsm: Tetris controller - spawn, gravity, button moves, lock, row clear, lines/level, game over.
module game_ctrl_fsm #(
  parameter int BOARD_W       = 10,
  parameter int BOARD_H       = 16,
  parameter int X_W           = 4,
  parameter int Y_W           = 4,
  parameter int GRAV_W        = 20,
  parameter int GRAV_BASE     = 800000,
  parameter int LVL_W         = 4,
  parameter int LINES_PER_LVL = 10,
  parameter int LINE_W        = 12
) (
  input  logic              clka,
  input  logic              restart_n,
  input  logic              start_i,
  input  logic              btn_left_i,
  input  logic              btn_right_i,
  input  logic              btn_rotate_i,
  input  logic              btn_down_i,
  input  logic [2:0]        rand_piece_i,
  game_ctrl_if.master       bus,
  output logic [2:0]        cur_piece_o,
  output logic [X_W-1:0]    cur_x_o,
  output logic [Y_W-1:0]    cur_y_o,
  output logic [1:0]        cur_rot_o,
  output logic [LINE_W-1:0] lines_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              game_over_o,
  output logic [3:0]        state_o
);
  typedef enum logic [3:0] {IDLE = 4'd0, SPAWN = 4'd1, PLAY = 4'd2, TEST = 4'd3,
                            LOCK = 4'd4, CLEAR = 4'd5, OVER = 4'd6} state_t;
  localparam logic [2:0] K_SPAWN = 3'd0, K_DOWN = 3'd4;
  localparam int RW = $clog2(LINES_PER_LVL + 5) + 1;

  state_t            state_q;
  logic [2:0]        cur_piece_q, cand_piece_q, kind_q;
  logic [X_W-1:0]    cur_x_q, cand_x_q;
  logic [Y_W-1:0]    cur_y_q, cand_y_q;
  logic [1:0]        cur_rot_q, cand_rot_q, pend_m_q;
  logic              fail_q, test_req_q, lock_req_q, clear_req_q, game_over_q, pend_v_q, grav_pend_q;
  logic [GRAV_W-1:0] grav_q;
  logic [LINE_W-1:0] lines_q;
  logic [LVL_W-1:0]  level_q;
  logic [RW-1:0]     rows_q;

  logic [31:0]       shifted;
  logic [GRAV_W-1:0] period_d, grav_d;
  logic              grav_hit, issue, btn_any, mv_fail, pend_v_d, grav_pend_d;
  logic [1:0]        btn_m, mv_m, mv_rot, pend_m_d;
  logic [X_W-1:0]    mv_x;
  logic [Y_W-1:0]    mv_y;
  logic [LINE_W:0]   lines_sum;
  logic [RW-1:0]     rows_sum;

  // Move codes 0..3 = left, right, rotate, down; gravity is served as a down move.
  always_comb begin
    shifted     = 32'(GRAV_BASE) >> level_q;
    period_d    = (shifted == 32'd0) ? GRAV_W'(1) : GRAV_W'(shifted);
    grav_d      = grav_q + 1'b1;
    grav_hit    = grav_d >= period_d;
    btn_any     = btn_left_i | btn_right_i | btn_rotate_i | btn_down_i;
    btn_m       = btn_left_i ? 2'd0 : btn_right_i ? 2'd1 : btn_rotate_i ? 2'd2 : 2'd3;
    issue       = (state_q == PLAY) && (pend_v_q || grav_pend_q);
    mv_m        = pend_v_q ? pend_m_q : 2'd3;
    mv_x        = (mv_m == 2'd0) ? cur_x_q - 1'b1 : (mv_m == 2'd1) ? cur_x_q + 1'b1 : cur_x_q;
    mv_y        = (mv_m == 2'd3) ? cur_y_q - 1'b1 : cur_y_q;
    mv_rot      = (mv_m == 2'd2) ? cur_rot_q + 1'b1 : cur_rot_q;
    mv_fail     = (mv_m == 2'd0 && cur_x_q == '0) || (mv_m == 2'd1 && cur_x_q == X_W'(BOARD_W - 1)) ||
                  (mv_m == 2'd3 && cur_y_q == '0);
    pend_v_d    = btn_any || (pend_v_q && !issue);
    pend_m_d    = btn_any ? btn_m : pend_m_q;
    grav_pend_d = (state_q == PLAY && grav_hit) || (grav_pend_q && !(issue && !pend_v_q));
    lines_sum   = {1'b0, lines_q} + (LINE_W + 1)'(bus.clear_rows);
    rows_sum    = rows_q + RW'(bus.clear_rows);
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q      <= IDLE;
      cur_piece_q  <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      cur_rot_q    <= '0;
      cand_piece_q <= '0;
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      cand_rot_q   <= '0;
      kind_q       <= '0;
      fail_q       <= 1'b0;
      test_req_q   <= 1'b0;
      lock_req_q   <= 1'b0;
      clear_req_q  <= 1'b0;
      game_over_q  <= 1'b0;
      pend_v_q     <= 1'b0;
      pend_m_q     <= '0;
      grav_pend_q  <= 1'b0;
      grav_q       <= '0;
      lines_q      <= '0;
      level_q      <= '0;
      rows_q       <= '0;
    end else begin
      pend_v_q    <= pend_v_d;
      pend_m_q    <= pend_m_d;
      grav_pend_q <= grav_pend_d;
      case (state_q)
        IDLE, OVER: if (start_i) begin
          grav_q      <= '0;
          lines_q     <= '0;
          level_q     <= '0;
          rows_q      <= '0;
          game_over_q <= 1'b0;
          state_q     <= SPAWN;
        end
        SPAWN: begin
          cand_piece_q <= rand_piece_i;
          cand_x_q     <= X_W'(BOARD_W / 2 - 2);
          cand_y_q     <= Y_W'(BOARD_H - 1);
          cand_rot_q   <= '0;
          kind_q       <= K_SPAWN;
          fail_q       <= 1'b0;
          test_req_q   <= 1'b1;
          state_q      <= TEST;
        end
        PLAY: begin
          grav_q <= grav_hit ? '0 : grav_d;
          if (issue) begin
            cand_piece_q <= cur_piece_q;
            cand_x_q     <= mv_x;
            cand_y_q     <= mv_y;
            cand_rot_q   <= mv_rot;
            kind_q       <= {1'b0, mv_m} + 3'd1;
            fail_q       <= mv_fail;
            test_req_q   <= !mv_fail;
            state_q      <= TEST;
          end
        end
        TEST: if (fail_q || bus.test_ack) begin
          test_req_q <= 1'b0;
          if (!fail_q && bus.test_ok) begin
            cur_piece_q <= cand_piece_q;
            cur_x_q     <= cand_x_q;
            cur_y_q     <= cand_y_q;
            cur_rot_q   <= cand_rot_q;
            state_q     <= PLAY;
          end else if (kind_q == K_SPAWN) begin
            game_over_q <= 1'b1;
            state_q     <= OVER;
          end else if (kind_q == K_DOWN) begin
            lock_req_q <= 1'b1;
            state_q    <= LOCK;
          end else state_q <= PLAY;
        end
        LOCK: if (bus.lock_ack) begin
          lock_req_q  <= 1'b0;
          clear_req_q <= 1'b1;
          state_q     <= CLEAR;
        end
        CLEAR: if (bus.clear_ack) begin
          clear_req_q <= 1'b0;
          lines_q     <= lines_sum[LINE_W] ? '1 : lines_sum[LINE_W-1:0];
          rows_q      <= (rows_sum >= RW'(LINES_PER_LVL)) ? rows_sum - RW'(LINES_PER_LVL) : rows_sum;
          level_q     <= (rows_sum >= RW'(LINES_PER_LVL) && !(&level_q)) ? level_q + 1'b1 : level_q;
          state_q     <= SPAWN;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.test_req   = test_req_q;
  assign bus.test_piece = cand_piece_q;
  assign bus.test_x     = cand_x_q;
  assign bus.test_y     = cand_y_q;
  assign bus.test_rot   = cand_rot_q;
  assign bus.lock_req   = lock_req_q;
  assign bus.clear_req  = clear_req_q;
  assign cur_piece_o    = cur_piece_q;
  assign cur_x_o        = cur_x_q;
  assign cur_y_o        = cur_y_q;
  assign cur_rot_o      = cur_rot_q;
  assign lines_o        = lines_q;
  assign level_o        = level_q;
  assign game_over_o    = game_over_q;
  assign state_o        = state_q;
endmodule

// File: tb/tb_game_ctrl_fsm.sv
// tb_game_ctrl_fsm: directed scenarios plus randomized play checked every cycle against a game-level model.
module tb_game_ctrl_fsm;
  localparam int BW = 10, BH = 16, XW = 4, YW = 4, GW = 20, GB = 8, LW = 3, LPL = 10, LNW = 6;
  localparam int MAXL = 2 ** LW - 1, MAXLN = 2 ** LNW - 1;

  logic clk = 0, restart_n = 0, start = 0, bl = 0, br = 0, brot = 0, bd = 0;
  logic [2:0] rp = 0, c_rows = 0;
  logic t_ack = 0, t_ok = 0, l_ack = 0, c_ack = 0;
  logic [2:0] cur_piece;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic [1:0] cur_rot;
  logic [LNW-1:0] lines;
  logic [LW-1:0] level;
  logic game_over;
  logic [3:0] state;

  game_ctrl_if #(.X_W(XW), .Y_W(YW)) bus();
  assign bus.test_ack = t_ack;
  assign bus.test_ok = t_ok;
  assign bus.lock_ack = l_ack;
  assign bus.clear_ack = c_ack;
  assign bus.clear_rows = c_rows;

  game_ctrl_fsm #(.BOARD_W(BW), .BOARD_H(BH), .X_W(XW), .Y_W(YW), .GRAV_W(GW), .GRAV_BASE(GB),
                  .LVL_W(LW), .LINES_PER_LVL(LPL), .LINE_W(LNW)) dut (
    .clka(clk), .restart_n(restart_n), .start_i(start), .btn_left_i(bl), .btn_right_i(br),
    .btn_rotate_i(brot), .btn_down_i(bd), .rand_piece_i(rp), .bus(bus),
    .cur_piece_o(cur_piece), .cur_x_o(cur_x), .cur_y_o(cur_y), .cur_rot_o(cur_rot),
    .lines_o(lines), .level_o(level), .game_over_o(game_over), .state_o(state));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int env_mode = 1, rows_fix = 4;
  int dx[4] = '{-1, 1, 0, 0};
  int dy[4] = '{0, 0, 0, -1};
  int dr[4] = '{0, 0, 1, 0};
  // Model: phase uses the published state codes; moves are 0..3 = left, right, rotate, down.
  int m_ph, m_treq, m_lreq, m_creq, m_cp, m_cx, m_cy, m_cr, m_kind, m_fail;
  int m_p, m_x, m_y, m_r, m_lines, m_level, m_rows, m_gcnt, m_gpend, m_pend, m_over;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait budget expired, model phase %0d at %0t", name, m_ph, $time);
  endtask

  function automatic int period();
    int p;
    p = GB >> m_level;
    return (p < 1) ? 1 : p;
  endfunction

  task automatic model_reset();
    {m_ph, m_treq, m_lreq, m_creq, m_cp, m_cx, m_cy, m_cr, m_kind, m_fail} = '0;
    {m_p, m_x, m_y, m_r, m_lines, m_level, m_rows, m_gcnt, m_gpend, m_over} = '0;
    m_pend = -1;
  endtask

  task automatic model_step();
    int bnew, issue, hit, mv, nx, ny;
    bnew = bl ? 0 : br ? 1 : brot ? 2 : bd ? 3 : -1;
    issue = (m_ph == 2) && (m_pend >= 0 || m_gpend != 0);
    hit = (m_ph == 2) && (m_gcnt + 1 >= period());
    mv = (m_pend >= 0) ? m_pend : 3;
    case (m_ph)
      0, 6: if (start) begin
        m_lines = 0; m_level = 0; m_rows = 0; m_gcnt = 0; m_over = 0; m_ph = 1;
      end
      1: begin
        m_cp = rp; m_cx = BW / 2 - 2; m_cy = BH - 1; m_cr = 0; m_kind = 0; m_fail = 0; m_treq = 1; m_ph = 3;
      end
      2: begin
        m_gcnt = hit ? 0 : m_gcnt + 1;
        if (issue) begin
          nx = m_x + dx[mv];
          ny = m_y + dy[mv];
          m_fail = (nx < 0 || nx >= BW || ny < 0) ? 1 : 0;
          m_cp = m_p; m_cx = nx; m_cy = ny; m_cr = (m_r + dr[mv]) % 4;
          m_kind = mv + 1; m_treq = !m_fail; m_ph = 3;
        end
      end
      3: if (m_fail != 0 || t_ack) begin
        m_treq = 0;
        if (m_fail == 0 && t_ok) begin
          m_p = m_cp; m_x = m_cx; m_y = m_cy; m_r = m_cr; m_ph = 2;
        end else if (m_kind == 0) begin
          m_over = 1; m_ph = 6;
        end else if (m_kind == 4) begin
          m_lreq = 1; m_ph = 4;
        end else m_ph = 2;
      end
      4: if (l_ack) begin
        m_lreq = 0; m_creq = 1; m_ph = 5;
      end
      5: if (c_ack) begin
        m_creq = 0;
        m_lines = (m_lines + c_rows > MAXLN) ? MAXLN : m_lines + c_rows;
        m_rows += c_rows;
        if (m_rows >= LPL) begin
          m_rows -= LPL;
          if (m_level < MAXL) m_level++;
        end
        m_ph = 1;
      end
      default: m_ph = 0;
    endcase
    m_gpend = (hit || (m_gpend != 0 && !(issue && m_pend < 0))) ? 1 : 0;
    m_pend = (bnew >= 0) ? bnew : (issue ? -1 : m_pend);
  endtask

  task automatic compare_all();
    chk("state", state, m_ph);
    chk("test_req", bus.test_req, m_treq);
    if (m_treq != 0) begin
      chk("test_piece", bus.test_piece, m_cp);
      chk("test_x", bus.test_x, m_cx);
      chk("test_y", bus.test_y, m_cy);
      chk("test_rot", bus.test_rot, m_cr);
    end
    chk("lock_req", bus.lock_req, m_lreq);
    chk("clear_req", bus.clear_req, m_creq);
    chk("cur_piece", cur_piece, m_p);
    chk("cur_x", cur_x, m_x);
    chk("cur_y", cur_y, m_y);
    chk("cur_rot", cur_rot, m_r);
    chk("lines", lines, m_lines);
    chk("level", level, m_level);
    chk("game_over", game_over, m_over);
  endtask

  // Environment: mode 0 random, 1 always ok, 2 gravity fails below y=5, 3 spawn fails, 4 never acks.
  task automatic env_drive();
    t_ack = (m_treq != 0) && env_mode != 4 && (env_mode != 0 || $urandom % 3 == 0);
    case (env_mode)
      0: t_ok = (m_kind == 0) ? ($urandom % 16 != 0) : ($urandom % 4 != 0);
      2: t_ok = !(m_kind == 4 && m_cy < 5);
      3: t_ok = (m_kind != 0);
      default: t_ok = 1'b1;
    endcase
    l_ack = (m_lreq != 0) && (env_mode != 0 || $urandom % 2 == 1);
    c_ack = (m_creq != 0) && (env_mode != 0 || $urandom % 2 == 1);
    c_rows = (rows_fix < 0) ? 3'($urandom % 5) : 3'(rows_fix);
  endtask

  task automatic tick();
    env_drive();
    model_step();
    @(negedge clk);
    compare_all();
    {start, bl, br, brot, bd, t_ack, l_ack, c_ack} = '0;
  endtask

  task automatic run_until(input int target, input int budget, input string name);
    int n = 0;
    while (m_ph != target && n < budget) begin
      tick();
      n++;
    end
    if (m_ph != target) timeout(name);
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    while (!(m_ph == 2 && m_pend < 0 && m_gpend == 0 && m_gcnt + 2 < period()) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) timeout(name);
  endtask

  task automatic async_reset(input string name);
    #2 restart_n = 0;
    #1;
    chk({name, "_test_req"}, bus.test_req, 0);
    chk({name, "_lock_req"}, bus.lock_req, 0);
    chk({name, "_clear_req"}, bus.clear_req, 0);
    model_reset();
    @(negedge clk);
    restart_n = 1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    @(negedge clk);
    compare_all();
    chk("rst_state", state, 0);
    chk("rst_lines", lines, 0);
    restart_n = 1;
    rp = 3;
    start = 1;
    tick();
    chk("t1_spawn_state", state, 1);
    tick();
    chk("t1_req", bus.test_req, 1);
    chk("t1_piece", bus.test_piece, 3);
    chk("t1_x", bus.test_x, 3);
    chk("t1_y", bus.test_y, 15);
    chk("t1_rot", bus.test_rot, 0);
    tick();
    chk("t1_play", state, 2);
    chk("t1_cur_x", cur_x, 3);
    chk("t1_cur_y", cur_y, 15);
    n = 0;
    while (!(m_ph == 2 && m_pend < 0 && m_gpend == 0 && m_gcnt + 1 == period()) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) timeout("t4_align");
    br = 1;
    tick();
    tick();
    chk("t4_right_req", bus.test_req, 1);
    chk("t4_right_x", bus.test_x, 4);
    chk("t4_right_y", bus.test_y, 15);
    tick();
    tick();
    chk("t4_grav_req", bus.test_req, 1);
    chk("t4_grav_x", bus.test_x, 4);
    chk("t4_grav_y", bus.test_y, 14);
    wait_quiet("t2_q0");
    for (int i = 0; i < 4; i++) begin
      bl = 1;
      tick();
      wait_quiet("t2_left");
    end
    chk("t2_at_left_edge", cur_x, 0);
    bl = 1;
    tick();
    tick();
    chk("t2_fail_state", state, 3);
    chk("t2_fail_no_req", bus.test_req, 0);
    tick();
    chk("t2_back_play", state, 2);
    chk("t2_x_kept", cur_x, 0);
    for (int i = 0; i < 3; i++) begin
      brot = 1;
      tick();
      wait_quiet("t2_rot");
    end
    chk("t2_rot3", cur_rot, 3);
    brot = 1;
    tick();
    tick();
    chk("t2_wrap_req", bus.test_req, 1);
    chk("t2_wrap_rot", bus.test_rot, 0);
    env_mode = 2;
    run_until(4, 400, "t3_lock_a");
    run_until(1, 50, "t3_spawn_a");
    chk("t3_lines4", lines, 4);
    run_until(4, 400, "t3_lock_b");
    chk("t3_lock_req", bus.lock_req, 1);
    chk("t3_lock_y", cur_y, 5);
    chk("t3_lock_x", cur_x, 3);
    run_until(1, 50, "t3_spawn_b");
    chk("t5_lines8", lines, 8);
    chk("t5_level0", level, 0);
    run_until(4, 400, "t5_lock_c");
    run_until(1, 50, "t5_spawn_c");
    chk("t5_lines12", lines, 12);
    chk("t5_level1", level, 1);
    env_mode = 3;
    run_until(6, 20, "t6_over");
    chk("t6_game_over", game_over, 1);
    chk("t6_state", state, 6);
    env_mode = 1;
    start = 1;
    tick();
    chk("t6_restart_state", state, 1);
    chk("t6_lines0", lines, 0);
    chk("t6_level0", level, 0);
    chk("t6_over_clr", game_over, 0);
    env_mode = 4;
    run_until(3, 10, "t6_test");
    chk("t6_req_before_rst", bus.test_req, 1);
    async_reset("t6_rst");
    env_mode = 0;
    rows_fix = -1;
    for (int i = 0; i < 20000; i++) begin
      int r;
      if (i % 5000 == 4999) async_reset("rand_rst");
      r = int'($urandom % 24);
      bl = (r == 0 || r == 4);
      br = (r == 1 || r == 4);
      brot = (r == 2 || r == 5);
      bd = (r == 3 || r == 5);
      start = ($urandom % 40 == 0);
      rp = 3'($urandom % 7);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
